demux4_router: RTL and testbench
================================

// Module: demux4_router
// PURPOSE
//  Buffered 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 datapath muxes.
//  Accepts one 32-bit word per cycle, tagged with a 2-bit destination select, on a valid/ready input.
//  Routes it into one of four per-destination FIFOs, each drained by its own valid/ready output.
//  Sits between a producer (e.g. writeback/result bus) and four consumers with independent backpressure.
// PARAMETERS
//  WIDTH   32  data word width in bits
//  DEPTH   2   entries per destination FIFO; power of two, >= 2
//  CNT_W   16  width of each per-destination transfer counter (only with DEMUX4_STATS_EN)
// PORTS
//  clk        in   1        rising-edge clock, single clock domain
//  reset      in   1        synchronous, active-high reset
//  in_data    in   WIDTH    input word
//  in_sel     in   2        destination: 00->ch0, 01->ch1, 10->ch2, 11->ch3
//  in_valid   in   1        input word/sel valid
//  in_ready   out  1        selected channel can accept this cycle
//  out_data   out  4*WIDTH  channel i head word at [i*WIDTH +: WIDTH]
//  out_valid  out  4        bit i: channel i FIFO non-empty
//  out_ready  in   4        bit i: consumer i accepts head word
//  stat_cnt   out  4*CNT_W  channel i accepted-word count at [i*CNT_W +: CNT_W] (DEMUX4_STATS_EN only)
// BEHAVIOUR
//  - Clock/reset: one clock, clk; reset is synchronous and active-high, sampled on clk rising edge.
//  - Reset: all FIFOs empty; out_valid=4'b0000; out_data=0; stat_cnt=0. in_ready=0 while reset=1.
//  - in_ready = (count[in_sel] < DEPTH), from registered count only; combinational in in_sel, never in_valid.
//  - Push: in_valid && in_ready at posedge -> in_data written at tail of FIFO[in_sel].
//  - Pop: out_valid[i] && out_ready[i] at posedge -> head of FIFO i removed.
//  - Latency: word pushed at edge N is visible on out_valid/out_data of its channel after edge N; no
//    same-cycle combinational pass-through from in_* to out_*.
//  - Order: per-channel FIFO order preserved; no ordering across channels.
//  - in_sel, in_data, in_valid and out_ready are ignored unless the respective handshake completes.
//  - Simultaneous push and pop on same channel: count unchanged, both take effect.
//  - Full channel: in_ready=0 even if that channel pops this cycle (no pop-to-push bypass); other
//    channels stay independent (sel to a non-full channel -> in_ready=1).
//  - Empty channel: out_valid[i]=0; out_data slice holds its last value; out_ready[i] ignored.
//  - Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  - Reset mid-operation: all buffered words discarded; state identical to post-reset in the next cycle.
// CONFIGURATION
//  - Macro DEMUX4_STATS_EN defined: stat_cnt port present; counter i increments by 1 on each
//    accepted push to channel i; wraps 2^CNT_W-1 -> 0; cleared by reset.
//  - Macro DEMUX4_STATS_EN undefined: stat_cnt port and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared defines header demux4_defs.vh: channel-select encodings DEMUX4_CH0..CH3 (2'd0..2'd3),
//    channel count (4).
//  - One sub-module demux4_fifo (WIDTH, DEPTH): synchronous FIFO with push/pop, full/empty/count,
//    head data. Instantiated 4x via generate; top holds select decode, in_ready mux, optional counters.
// TESTING
//  1. Reset held 2 cycles -> out_valid=0000, out_data=0, in_ready=0; release -> in_ready=1 for any sel.
//  2. sel=10, data=32'h4, valid 1 cycle, out_ready=0000 -> after edge out_valid=0100, ch2 data=32'h4;
//     pulse out_ready[2] -> out_valid=0000.
//  3. out_ready=0000, push 32'hA,32'hB to sel=01 -> in_ready=0 for sel=01, 1 for sel=00; drain ch1
//     -> reads 32'hA then 32'hB.
//  4. ch3 holds 1 word, push 32'hC to ch3 with out_ready[3]=1 same cycle -> count stays 1, head=32'hC.
//  5. Fill ch0 with 2 words, assert reset 1 cycle mid-stream -> all out_valid=0; old words never emerge.
//  6. DEMUX4_STATS_EN, CNT_W=4: 17 pushes to ch1 -> stat_cnt ch1 = 1 (wrapped), others 0.

Source files
------------

// File: rtl/demux4_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux4_router_pkg
// Brief    : Shared types and select-decode helper for the demux4 router.
// Revision : 1.0 - initial release
// ============================================================================
`include "demux4_defs.vh"

package demux4_router_pkg;
  localparam int N_CH = `DEMUX4_NUM_CH;

  typedef logic [1:0] ch_sel_t;

  function automatic logic [N_CH-1:0] sel_onehot(input ch_sel_t s);
    logic [N_CH-1:0] v;
    case (s)
      `DEMUX4_CH0: v = 4'b0001;
      `DEMUX4_CH1: v = 4'b0010;
      `DEMUX4_CH2: v = 4'b0100;
      default:     v = 4'b1000;
    endcase
    return v;
  endfunction
endpackage

`default_nettype wire

// File: rtl/demux4_defs.vh
`ifndef DEMUX4_DEFS_VH
`define DEMUX4_DEFS_VH
// Channel-select encodings and channel count shared by the demux4 router files.
`define DEMUX4_CH0    2'd0
`define DEMUX4_CH1    2'd1
`define DEMUX4_CH2    2'd2
`define DEMUX4_CH3    2'd3
`define DEMUX4_NUM_CH 4
`endif

// File: rtl/demux4_fifo.sv
`default_nettype none
// ============================================================================
// Module   : demux4_fifo
// Brief    : Synchronous FIFO with registered head word that holds when empty.
// Revision : 1.0 - initial release
// ============================================================================
module demux4_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rptr_n;
  logic [AW:0]      w_count_n;
  logic [WIDTH-1:0] w_head_n;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_count  = r_count;
  assign o_data   = r_head;
  assign w_push   = i_push & ~o_full;
  assign w_pop    = i_pop & ~o_empty;
  assign w_rptr_n = w_pop ? r_rptr + 1'b1 : r_rptr;

  always_comb begin
    w_count_n = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + 1'b1;
      2'b01:   w_count_n = r_count - 1'b1;
      default: w_count_n = r_count;
    endcase
  end

  // Next head is the incoming word only when no older entry survives this edge.
  always_comb begin
    w_head_n = r_head;
    if (w_count_n != '0) begin
      if (w_push && (r_count == (AW+1)'(w_pop)))
        w_head_n = i_data;
      else
        w_head_n = r_mem[w_rptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      r_rptr  <= w_rptr_n;
      r_count <= w_count_n;
      r_head  <= w_head_n;
    end
  end
endmodule

`default_nettype wire

// File: rtl/demux4_router.sv
`default_nettype none
// ============================================================================
// Module   : demux4_router
// Brief    : Buffered 1-to-4 demux with per-destination FIFOs and backpressure.
//            Optional per-channel accepted-word counters via DEMUX4_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module demux4_router
  import demux4_router_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
`ifdef DEMUX4_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
`ifdef DEMUX4_STATS_EN
  output logic [4*CNT_W-1:0]   stat_cnt,
`endif
  input  logic [3:0]           out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   w_count [N_CH];
  logic [N_CH-1:0] w_empty;
  logic [N_CH-1:0] w_full;
  logic [N_CH-1:0] w_push;
  logic [N_CH-1:0] w_sel_oh;

  // Readiness depends only on registered occupancy, so a pop cannot free a slot same-cycle.
  assign in_ready = !reset && (w_count[in_sel] < CW'(DEPTH));
  assign w_sel_oh = sel_onehot(in_sel);
  assign w_push   = (in_valid && in_ready) ? w_sel_oh : '0;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    demux4_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push[i]),
      .i_data  (in_data),
      .i_pop   (out_ready[i]),
      .o_data  (out_data[i*WIDTH +: WIDTH]),
      .o_empty (w_empty[i]),
      .o_full  (w_full[i]),
      .o_count (w_count[i])
    );
    assign out_valid[i] = ~w_empty[i];

`ifdef DEMUX4_STATS_EN
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (reset)
        r_cnt <= '0;
      else if (w_push[i])
        r_cnt <= r_cnt + 1'b1;
    end
    assign stat_cnt[i*CNT_W +: CNT_W] = r_cnt;
`endif
  end

  logic w_unused;
  assign w_unused = ^w_full;
endmodule

`default_nettype wire

// File: tb/tb_demux4_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4_router
// Brief    : Self-checking bench: vector table, directed sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux4_router;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] stat_cnt;

  int checks = 0;
  int errors = 0;

  demux4_router #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
`ifdef DEMUX4_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef DEMUX4_STATS_EN
    .stat_cnt  (stat_cnt),
`endif
    .out_ready (out_ready)
  );

`ifndef DEMUX4_STATS_EN
  assign stat_cnt = '0;
`endif

  always #5 clk = ~clk;

  // Reference model: one queue per channel, last-seen head word, accepted-word counts.
  logic [WIDTH-1:0] q [4][$];
  logic [WIDTH-1:0] last_head [4];
  int unsigned      mcnt [4];

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic        valid;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_v;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return !reset && (q[in_sel].size() < DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      last_head[i] = '0;
      mcnt[i] = 0;
    end
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    bit rs;
    bit push;
    bit [3:0] pop;
    logic [1:0] s;
    logic [WIDTH-1:0] d;
    rs = reset;
    s = in_sel;
    d = in_data;
    push = in_valid && m_ready();
    for (int i = 0; i < 4; i++) pop[i] = (q[i].size() > 0) && out_ready[i];
    @(posedge clk);
    #1;
    if (rs) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) if (pop[i]) void'(q[i].pop_front());
      if (push) begin
        q[s].push_back(d);
        mcnt[s] = (mcnt[s] + 1) % (1 << CNT_W);
      end
    end
    for (int i = 0; i < 4; i++) if (q[i].size() > 0) last_head[i] = q[i][0];
  endtask

  task automatic check_model(input string tag);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, 64'(out_valid[i]), 64'(q[i].size() != 0));
      chk({tag, "_data"}, 64'(out_data[i*WIDTH +: WIDTH]), 64'(last_head[i]));
`ifdef DEMUX4_STATS_EN
      chk({tag, "_stat"}, 64'(stat_cnt[i*CNT_W +: CNT_W]), 64'(mcnt[i]));
`endif
    end
    chk({tag, "_ready"}, 64'(in_ready), 64'(m_ready()));
  endtask

  task automatic drive(input logic [1:0] s, input logic [31:0] d, input logic v,
                       input logic [3:0] o);
    in_sel = s;
    in_data = d;
    in_valid = v;
    out_ready = o;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive(2'd0, 32'h0, 1'b0, 4'b0000);
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    tbl[0] = '{2'd0, 32'h11, 1'b1, 4'b0000, 1'b1, 4'b0001};
    tbl[1] = '{2'd0, 32'h12, 1'b1, 4'b0000, 1'b1, 4'b0001};
    tbl[2] = '{2'd0, 32'h13, 1'b1, 4'b0001, 1'b0, 4'b0001};
    tbl[3] = '{2'd3, 32'h31, 1'b1, 4'b0001, 1'b1, 4'b1000};
    tbl[4] = '{2'd3, 32'h32, 1'b0, 4'b1000, 1'b1, 4'b0000};

    // Reset held two cycles, then readiness on every select.
    do_reset(2);
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(|out_data), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h0);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("post_rst_ready", 64'(in_ready), 64'h1);
    end

    // Vector table from empty.
    for (int k = 0; k < 5; k++) begin
      drive(tbl[k].sel, tbl[k].data, tbl[k].valid, tbl[k].ordy);
      #1;
      chk("tbl_ready", 64'(in_ready), 64'(tbl[k].exp_rdy));
      tick();
      chk("tbl_valid", 64'(out_valid), 64'(tbl[k].exp_v));
      check_model("tbl");
    end

    // Single word to ch2, then drain.
    do_reset(1);
    drive(2'd2, 32'h4, 1'b1, 4'b0000);
    tick();
    drive(2'd0, 32'h0, 1'b0, 4'b0000);
    #1;
    chk("t2_valid", 64'(out_valid), 64'h4);
    chk("t2_data", 64'(out_data[2*WIDTH +: WIDTH]), 64'h4);
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("t2_drain", 64'(out_valid), 64'h0);
    check_model("t2");

    // Fill ch1, check per-channel backpressure, drain in order.
    drive(2'd1, 32'hA, 1'b1, 4'b0000);
    tick();
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t3_full_ready", 64'(in_ready), 64'h0);
    in_sel = 2'd0;
    #1;
    chk("t3_other_ready", 64'(in_ready), 64'h1);
    chk("t3_head0", 64'(out_data[1*WIDTH +: WIDTH]), 64'hA);
    out_ready = 4'b0010;
    tick();
    chk("t3_head1", 64'(out_data[1*WIDTH +: WIDTH]), 64'hB);
    tick();
    out_ready = 4'b0000;
    chk("t3_empty", 64'(out_valid), 64'h0);
    check_model("t3");

    // Simultaneous push and pop on ch3 holding one word.
    drive(2'd3, 32'h77, 1'b1, 4'b0000);
    tick();
    drive(2'd3, 32'hC, 1'b1, 4'b1000);
    #1;
    chk("t4_ready", 64'(in_ready), 64'h1);
    tick();
    drive(2'd0, 32'h0, 1'b0, 4'b0000);
    chk("t4_head", 64'(out_data[3*WIDTH +: WIDTH]), 64'hC);
    chk("t4_valid", 64'(out_valid), 64'h8);
    out_ready = 4'b1000;
    tick();
    chk("t4_count1", 64'(out_valid), 64'h0);
    check_model("t4");

    // Reset mid-stream discards buffered words.
    drive(2'd0, 32'hD0, 1'b1, 4'b0000);
    tick();
    in_data = 32'hD1;
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t5_ready_in_rst", 64'(in_ready), 64'h0);
    tick();
    reset = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'h0);
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_old", 64'(out_valid), 64'h0);
    end
    check_model("t5");

`ifdef DEMUX4_STATS_EN
    // Counter wrap: 17 accepted pushes to ch1 with a 4-bit counter.
    do_reset(1);
    drive(2'd1, 32'h0, 1'b1, 4'b1111);
    for (int i = 0; i < 17; i++) begin
      in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t6_ch1", 64'(stat_cnt[1*CNT_W +: CNT_W]), 64'h1);
    chk("t6_ch0", 64'(stat_cnt[0*CNT_W +: CNT_W]), 64'h0);
    chk("t6_ch2", 64'(stat_cnt[2*CNT_W +: CNT_W]), 64'h0);
    chk("t6_ch3", 64'(stat_cnt[3*CNT_W +: CNT_W]), 64'h0);
`endif

    // Randomized traffic against the model.
    do_reset(1);
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      in_sel = 2'($urandom_range(0, 3));
      in_data = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(0, 2) == 0);
      check_model("rnd");
      tick();
    end
    reset = 1'b0;
    check_model("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
